// File: rtl/cubic_pkg.sv
// Shared mode codes, FSM state encoding and width helper for the cubic interpolation engine.
package cubic_pkg;

   typedef enum logic [1:0] {
      MODE_CUBIC   = 2'd0,
      MODE_LINEAR  = 2'd1,
      MODE_NEAREST = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_H1   = 3'd1,
      ST_H2   = 3'd2,
      ST_H3   = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

   // Headroom for three exact Horner steps of a (DATA_W+4)-bit coefficient by FRAC_W-bit t.
   function automatic int acc_width(input int data_w, input int frac_w);
      return data_w + 32'sd3 * frac_w + 32'sd6;
   endfunction

endpackage

// File: rtl/interp_round_clamp.sv
// Mode-dependent final scaling: round-half-up shift of the accumulator (or nearest pick), saturated to DATA_W.
module interp_round_clamp
   import cubic_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = acc_width(DATA_W, FRAC_W)
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  mode_t                    mode,
   input  logic        [DATA_W-1:0] p1,
   input  logic        [DATA_W-1:0] p2,
   input  logic        [FRAC_W-1:0] frac,
   output logic        [DATA_W-1:0] res
);

   localparam logic signed [ACC_W-1:0] CUBIC_HALF = ACC_W'(1'b1) << (3 * FRAC_W);
   localparam logic signed [ACC_W-1:0] LIN_HALF   = ACC_W'(1'b1) << (FRAC_W - 1);
   localparam logic signed [ACC_W-1:0] RES_MAX    = ACC_W'({DATA_W{1'b1}});

   logic signed [ACC_W-1:0] shifted_s;

   // Scale per mode, then saturate into the unsigned output range
   always_comb begin
      shifted_s = '0;
      res       = '0;
      case (mode)
         MODE_LINEAR:  shifted_s = (acc + LIN_HALF) >>> FRAC_W;
         MODE_NEAREST: shifted_s = frac[FRAC_W-1] ? $signed(ACC_W'(p2)) : $signed(ACC_W'(p1));
         default:      shifted_s = (acc + CUBIC_HALF) >>> (3 * FRAC_W + 1);
      endcase
      if (shifted_s[ACC_W-1]) begin
         res = '0;
      end else if (shifted_s > RES_MAX) begin
         res = '1;
      end else begin
         res = shifted_s[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/cubic_interp_engine.sv
// Catmull-Rom / linear / nearest interpolator with valid-ready handshakes and one shared
// multiplier running a fixed IDLE->H1->H2->H3->OUT schedule.
module cubic_interp_engine
   import cubic_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = acc_width(DATA_W, FRAC_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DATA_W-1:0]   in_p,
   input  logic [FRAC_W-1:0]     in_frac,
   input  logic [1:0]            in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data
);

   localparam int CW = DATA_W + 4;

   state_t                  state_r, state_nx_s;
   mode_t                   mode_r, mode_in_s;
   logic                    accept_s, use_mul_s;
   logic signed [CW-1:0]    p0_s, p1_s, p2_s, p3_s, d12_s;
   logic signed [CW-1:0]    coef_a_s, coef_b_s, coef_c_s, coef_d_s;
   logic signed [CW-1:0]    a_r, b_r, c_r, d_r;
   logic [DATA_W-1:0]       p1_r, p2_r;
   logic [FRAC_W-1:0]       frac_r;
   logic signed [ACC_W-1:0] acc_r, acc_nx_s, mul_a_s, add_s, frac_ext_s, prod_s;
   logic [DATA_W-1:0]       res_s, out_data_r;
   logic                    out_valid_r;

   assign in_ready  = (state_r == ST_IDLE);
   assign accept_s  = in_valid && in_ready;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;

   assign p0_s  = $signed({4'b0000, in_p[0*DATA_W +: DATA_W]});
   assign p1_s  = $signed({4'b0000, in_p[1*DATA_W +: DATA_W]});
   assign p2_s  = $signed({4'b0000, in_p[2*DATA_W +: DATA_W]});
   assign p3_s  = $signed({4'b0000, in_p[3*DATA_W +: DATA_W]});
   assign d12_s = p1_s - p2_s;

   // Catmull-Rom coefficients scaled by 2, built from shifts and adds
   assign coef_a_s = p3_s - p0_s + (d12_s <<< 1) + d12_s;
   assign coef_b_s = (p0_s <<< 1) - (p1_s <<< 2) - p1_s + (p2_s <<< 2) - p3_s;
   assign coef_c_s = p2_s - p0_s;
   assign coef_d_s = p1_s <<< 1;

   // Reserved mode code falls back to cubic at capture time
   always_comb begin
      mode_in_s = MODE_CUBIC;
      case (in_mode)
         2'd1:    mode_in_s = MODE_LINEAR;
         2'd2:    mode_in_s = MODE_NEAREST;
         default: mode_in_s = MODE_CUBIC;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: if (accept_s) state_nx_s = ST_H1; else state_nx_s = ST_IDLE;
         ST_H1:   state_nx_s = ST_H2;
         ST_H2:   state_nx_s = ST_H3;
         ST_H3:   state_nx_s = ST_OUT;
         ST_OUT:  if (out_ready) state_nx_s = ST_IDLE; else state_nx_s = ST_OUT;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Multiplier operand and addend selection; linear uses P1*S + (P2-P1)*t in one product
   always_comb begin
      mul_a_s   = '0;
      add_s     = '0;
      use_mul_s = 1'b0;
      case (state_r)
         ST_H1: begin
            if (mode_r == MODE_LINEAR) begin
               mul_a_s   = ACC_W'($signed({1'b0, p2_r})) - ACC_W'($signed({1'b0, p1_r}));
               add_s     = $signed(ACC_W'(p1_r)) <<< FRAC_W;
               use_mul_s = 1'b1;
            end else if (mode_r == MODE_NEAREST) begin
               use_mul_s = 1'b0;
            end else begin
               mul_a_s   = ACC_W'(a_r);
               add_s     = ACC_W'(b_r) <<< FRAC_W;
               use_mul_s = 1'b1;
            end
         end
         ST_H2: begin
            if (mode_r == MODE_CUBIC) begin
               mul_a_s   = acc_r;
               add_s     = ACC_W'(c_r) <<< (2 * FRAC_W);
               use_mul_s = 1'b1;
            end else begin
               use_mul_s = 1'b0;
            end
         end
         ST_H3: begin
            if (mode_r == MODE_CUBIC) begin
               mul_a_s   = acc_r;
               add_s     = ACC_W'(d_r) <<< (3 * FRAC_W);
               use_mul_s = 1'b1;
            end else begin
               use_mul_s = 1'b0;
            end
         end
         default: use_mul_s = 1'b0;
      endcase
   end

   assign frac_ext_s = $signed({{(ACC_W-FRAC_W){1'b0}}, frac_r});
   assign prod_s     = mul_a_s * frac_ext_s;
   assign acc_nx_s   = use_mul_s ? (prod_s + add_s) : acc_r;

   // Operand capture on accept, accumulator update otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         c_r    <= '0;
         d_r    <= '0;
         p1_r   <= '0;
         p2_r   <= '0;
         frac_r <= '0;
         mode_r <= MODE_CUBIC;
         acc_r  <= '0;
      end else if (accept_s) begin
         a_r    <= coef_a_s;
         b_r    <= coef_b_s;
         c_r    <= coef_c_s;
         d_r    <= coef_d_s;
         p1_r   <= in_p[1*DATA_W +: DATA_W];
         p2_r   <= in_p[2*DATA_W +: DATA_W];
         frac_r <= in_frac;
         mode_r <= mode_in_s;
         acc_r  <= '0;
      end else begin
         acc_r  <= acc_nx_s;
      end
   end

   // Final scaling sees the H3 result combinationally so it can be registered on the H3->OUT edge
   interp_round_clamp #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_round_clamp (
      .acc  (acc_nx_s),
      .mode (mode_r),
      .p1   (p1_r),
      .p2   (p2_r),
      .frac (frac_r),
      .res  (res_s)
   );

   // Registered result and valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else begin
         out_valid_r <= (state_nx_s == ST_OUT);
         if (state_r == ST_H3) begin
            out_data_r <= res_s;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

endmodule

// File: tb/tb_cubic_interp_engine.sv
// Directed self-checking bench for cubic_interp_engine with hand-computed expected samples.
module tb_cubic_interp_engine;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_p;
   logic [7:0]  in_frac;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;

   int checks = 0;
   int errors = 0;

   cubic_interp_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_frac   (in_frac),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   // Waits (bounded) for in_ready, presents one sample set for one accept edge, then scrambles inputs.
   task automatic issue(input string tag, input logic [31:0] p, input logic [7:0] f, input logic [1:0] m);
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_p     = p;
      in_frac  = f;
      in_mode  = m;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_mode  = ~m;
      in_p     = 32'hA5C3_5A3C;
      in_frac  = ~f;
   endtask

   // Counts edges from the acceptance edge (counted as 1) until out_valid, then checks data.
   task automatic wait_out(input string tag, input logic [7:0] want);
      int e = 1;
      while (out_valid !== 1'b1 && e < 12) begin
         @(posedge clk); #1;
         e++;
      end
      check({tag, "_latency"}, e, 32'd4);
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, want});
   endtask

   // Completes the output handshake with out_ready high and checks the return to IDLE.
   task automatic finish_out(input string tag);
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_p      = 32'd0;
      in_frac   = 8'd0;
      in_mode   = 2'd0;
      out_ready = 1'b1;
      #3;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      #19;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // P = (P0,P1,P2,P3), packed {P3,P2,P1,P0}
      issue("cub_mid", {8'd100, 8'd200, 8'd100, 8'd0}, 8'd128, 2'd0);
      wait_out("cub_mid", 8'd163);
      finish_out("cub_mid");

      issue("cub_t0", {8'd40, 8'd30, 8'd20, 8'd10}, 8'd0, 2'd0);
      wait_out("cub_t0", 8'd20);
      finish_out("cub_t0");

      issue("cub_hi", {8'd0, 8'd255, 8'd255, 8'd0}, 8'd128, 2'd0);
      wait_out("cub_hi", 8'd255);
      finish_out("cub_hi");

      issue("cub_lo", {8'd255, 8'd0, 8'd0, 8'd255}, 8'd128, 2'd0);
      wait_out("cub_lo", 8'd0);
      finish_out("cub_lo");

      issue("rsvd_mode", {8'd100, 8'd200, 8'd100, 8'd0}, 8'd128, 2'd3);
      wait_out("rsvd_mode", 8'd163);
      finish_out("rsvd_mode");

      issue("lin_mid", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd128, 2'd1);
      wait_out("lin_mid", 8'd151);
      finish_out("lin_mid");

      issue("lin_t0", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd0, 2'd1);
      wait_out("lin_t0", 8'd100);
      finish_out("lin_t0");

      issue("lin_tmax", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd255, 2'd1);
      wait_out("lin_tmax", 8'd201);
      finish_out("lin_tmax");

      issue("near_127", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd127, 2'd2);
      wait_out("near_127", 8'd100);
      finish_out("near_127");

      issue("near_128", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd128, 2'd2);
      wait_out("near_128", 8'd201);
      finish_out("near_128");

      issue("near_t0", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd0, 2'd2);
      wait_out("near_t0", 8'd100);
      finish_out("near_t0");

      // Backpressure: hold the result while upstream keeps offering work
      out_ready = 1'b0;
      issue("bp", {8'd100, 8'd200, 8'd100, 8'd0}, 8'd128, 2'd0);
      wait_out("bp", 8'd163);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_p     = {8'd9, 8'd250, 8'd1, 8'd77};
         in_mode  = 2'd1;
         @(posedge clk); #1;
         check("bp_hold_data", {24'd0, out_data}, 32'd163);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      finish_out("bp");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp_no_extra", {31'd0, out_valid}, 32'd0);
      end

      // Reset while the Horner schedule is in H2
      issue("rst_h2", {8'd7, 8'd201, 8'd100, 8'd3}, 8'd128, 2'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_h2_valid", {31'd0, out_valid}, 32'd0);
      check("rst_h2_data", {24'd0, out_data}, 32'd0);
      check("rst_h2_ready", {31'd0, in_ready}, 32'd1);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("rst_h2_no_out", {31'd0, out_valid}, 32'd0);
      end
      issue("post_rst", {8'd100, 8'd200, 8'd100, 8'd0}, 8'd128, 2'd0);
      wait_out("post_rst", 8'd163);
      finish_out("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
